// File: rtl/encrypter_collector_if.sv
// Bus bundle between the encrypter array / QSPI TX side and the collector.
// The slave modport is the collector's view; the master modport is the view of
// whatever drives results and consumes nibbles.
interface encrypter_collector_if #(
   parameter int NUM_ENCRYPTERS  = 4,
   parameter int ENCRYPTER_WIDTH = 32
);
   localparam int IDX_W     = (NUM_ENCRYPTERS > 1) ? $clog2(NUM_ENCRYPTERS) : 1;
   localparam int NIB_COUNT = ENCRYPTER_WIDTH / 4;
   localparam int NIB_W     = (NIB_COUNT > 1) ? $clog2(NIB_COUNT) : 1;

   logic [NUM_ENCRYPTERS*ENCRYPTER_WIDTH-1:0] enc_result_data;
   logic [NUM_ENCRYPTERS-1:0]                 enc_result_valid;
   logic [NUM_ENCRYPTERS-1:0]                 enc_result_ack;
   logic [3:0]                                qspi_out_data;
   logic                                      qspi_out_valid;
   logic                                      qspi_out_ready;
   logic                                      busy;
   logic [1:0]                                state_out;
   logic [IDX_W-1:0]                          enc_index_out;
   logic [NIB_W-1:0]                          nibble_index_out;

   modport slave (
      input  enc_result_data, enc_result_valid, qspi_out_ready,
      output enc_result_ack, qspi_out_data, qspi_out_valid, busy,
             state_out, enc_index_out, nibble_index_out
   );

   modport master (
      output enc_result_data, enc_result_valid, qspi_out_ready,
      input  enc_result_ack, qspi_out_data, qspi_out_valid, busy,
             state_out, enc_index_out, nibble_index_out
   );
endinterface

// File: rtl/encrypter_collector.sv
// Output-side sequencer for the encrypter array. Takes finished result packets
// from the encrypters in strict round-robin order and streams each one
// MSB-nibble-first onto the 4-bit QSPI return bus with a valid/ready handshake.
module encrypter_collector #(
   parameter int NUM_ENCRYPTERS  = 4,
   parameter int ENCRYPTER_WIDTH = 32
) (
   input  logic clk,
   input  logic reset,
   input  logic prog,
   encrypter_collector_if.slave bus
);
   localparam int EW        = ENCRYPTER_WIDTH;
   localparam int IDX_W     = (NUM_ENCRYPTERS > 1) ? $clog2(NUM_ENCRYPTERS) : 1;
   localparam int NIB_COUNT = ENCRYPTER_WIDTH / 4;
   localparam int NIB_W     = (NIB_COUNT > 1) ? $clog2(NIB_COUNT) : 1;

   typedef enum logic [1:0] {
      WAIT  = 2'd0,
      SHIFT = 2'd1
   } state_t;

   state_t                    state_reg, state_next;
   logic [IDX_W-1:0]          ptr_reg, ptr_next;
   logic [NIB_W-1:0]          nib_cnt_reg, nib_cnt_next;
   logic [EW-1:0]             shreg_reg, shreg_next;
   logic [NUM_ENCRYPTERS-1:0] ack_reg, ack_next;

   logic in_shift;
   logic last_nibble;
   logic last_ptr;

   assign in_shift    = (state_reg == SHIFT);
   assign last_nibble = (nib_cnt_reg == NIB_W'(NIB_COUNT - 1));
   assign last_ptr    = (ptr_reg == IDX_W'(NUM_ENCRYPTERS - 1));

   // Next-state logic: prog overrides everything; otherwise only the encrypter
   // under the pointer is looked at, and the pointer advances after the last nibble.
   always_comb begin
      state_next   = state_reg;
      ptr_next     = ptr_reg;
      nib_cnt_next = nib_cnt_reg;
      shreg_next   = shreg_reg;
      ack_next     = '0;
      if (prog) begin
         state_next   = WAIT;
         ptr_next     = '0;
         nib_cnt_next = '0;
      end else begin
         case (state_reg)
            WAIT: begin
               if (bus.enc_result_valid[ptr_reg]) begin
                  shreg_next        = bus.enc_result_data[ptr_reg*EW +: EW];
                  nib_cnt_next      = '0;
                  ack_next[ptr_reg] = 1'b1;
                  state_next        = SHIFT;
               end
            end
            SHIFT: begin
               if (bus.qspi_out_ready) begin
                  shreg_next = shreg_reg << 4;
                  if (last_nibble) begin
                     // Go straight back to WAIT so the next packet can be sampled
                     // on the very next edge.
                     nib_cnt_next = '0;
                     ptr_next     = last_ptr ? '0 : ptr_reg + 1'b1;
                     state_next   = WAIT;
                  end else begin
                     nib_cnt_next = nib_cnt_reg + 1'b1;
                  end
               end
            end
            default: state_next = WAIT;
         endcase
      end
   end

   // State register; reset clears everything at once, dropping any packet in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg   <= WAIT;
         ptr_reg     <= '0;
         nib_cnt_reg <= '0;
         shreg_reg   <= '0;
         ack_reg     <= '0;
      end else begin
         state_reg   <= state_next;
         ptr_reg     <= ptr_next;
         nib_cnt_reg <= nib_cnt_next;
         shreg_reg   <= shreg_next;
         ack_reg     <= ack_next;
      end
   end

   // Outputs are decoded straight from registers so they follow reset immediately.
   assign bus.enc_result_ack   = ack_reg;
   assign bus.qspi_out_valid   = in_shift;
   assign bus.qspi_out_data    = in_shift ? shreg_reg[EW-1 -: 4] : 4'd0;
   assign bus.busy             = in_shift;
   assign bus.state_out        = state_reg;
   assign bus.enc_index_out    = ptr_reg;
   assign bus.nibble_index_out = nib_cnt_reg;
endmodule

// File: tb/tb_encrypter_collector.sv
// Scoreboard bench for encrypter_collector: the stimulus pushes expected acks and
// nibbles into queues, a monitor pops and compares on every ack pulse and every
// accepted nibble.
module tb_encrypter_collector;
   localparam int N  = 4;
   localparam int EW = 32;

   logic clk = 1'b0;
   logic reset;
   logic prog;
   logic ready;
   logic [EW-1:0] enc_data [N];
   logic          enc_valid[N];
   bit            auto_clear;

   int checks = 0;
   int passes = 0;

   logic [3:0]   exp_nib[$];
   logic [N-1:0] exp_ack[$];

   encrypter_collector_if #(.NUM_ENCRYPTERS(N), .ENCRYPTER_WIDTH(EW)) bus ();

   encrypter_collector #(.NUM_ENCRYPTERS(N), .ENCRYPTER_WIDTH(EW)) dut (
      .clk   (clk),
      .reset (reset),
      .prog  (prog),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Pack the per-encrypter model state onto the flattened bus.
   always_comb begin
      bus.enc_result_data  = '0;
      bus.enc_result_valid = '0;
      for (int i = 0; i < N; i++) begin
         bus.enc_result_data[i*EW +: EW] = enc_data[i];
         bus.enc_result_valid[i]         = enc_valid[i];
      end
   end
   assign bus.qspi_out_ready = ready;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // One clock; encrypters drop valid as soon as they see their ack.
   task automatic cyc();
      @(posedge clk);
      #1;
      if (auto_clear)
         for (int i = 0; i < N; i++)
            if (bus.enc_result_ack[i]) enc_valid[i] = 1'b0;
   endtask

   task automatic push_nibs(input logic [31:0] d, input int cnt);
      for (int k = 0; k < cnt; k++) exp_nib.push_back(d[31-4*k -: 4]);
   endtask

   task automatic push_pkt(input int idx, input logic [31:0] d);
      logic [N-1:0] a;
      a = '0;
      a[idx] = 1'b1;
      exp_ack.push_back(a);
      push_nibs(d, 8);
   endtask

   // Wait until the collector is back in WAIT with the pointer on target.
   task automatic wait_ptr(input int target, output int n);
      n = 0;
      do begin
         cyc();
         n++;
      end while (!(bus.state_out == 2'd0 && bus.enc_index_out == target[1:0]) && n < 300);
      if (n >= 300) check("wait_ptr_timeout", 32'(n), 32'(target));
   endtask

   task automatic do_prog();
      prog = 1'b1;
      cyc();
      prog = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_valid"}, 32'(bus.qspi_out_valid), 0);
      check({tag, "_data"},  32'(bus.qspi_out_data), 0);
      check({tag, "_ack"},   32'(bus.enc_result_ack), 0);
      check({tag, "_busy"},  32'(bus.busy), 0);
      check({tag, "_state"}, 32'(bus.state_out), 0);
      check({tag, "_ptr"},   32'(bus.enc_index_out), 0);
      check({tag, "_nib"},   32'(bus.nibble_index_out), 0);
   endtask

   // Monitor: compares every ack pulse and every accepted nibble against the
   // scoreboard, and checks data stays put while the receiver stalls.
   initial begin
      logic       stalled_prev;
      logic [3:0] held;
      stalled_prev = 1'b0;
      held = '0;
      forever begin
         @(negedge clk);
         if (bus.enc_result_ack != '0) begin
            if (exp_ack.size() == 0) check("unexpected_ack", 32'(bus.enc_result_ack), 0);
            else check("ack", 32'(bus.enc_result_ack), 32'(exp_ack.pop_front()));
         end
         if (bus.qspi_out_valid) begin
            if (stalled_prev) check("stall_data_stable", 32'(bus.qspi_out_data), 32'(held));
            if (bus.qspi_out_ready) begin
               stalled_prev = 1'b0;
               if (exp_nib.size() == 0) check("unexpected_nibble", 32'(bus.qspi_out_data), 32'hFFFF);
               else check("nibble", 32'(bus.qspi_out_data), 32'(exp_nib.pop_front()));
            end else begin
               stalled_prev = 1'b1;
               held = bus.qspi_out_data;
            end
         end else begin
            stalled_prev = 1'b0;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      bit pat[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      logic [31:0] t4_data[5] = '{32'h01234567, 32'h89ABCDEF, 32'hFEDCBA98,
                                  32'h76543210, 32'h0F0F0F0F};
      reset = 1'b1;
      prog = 1'b0;
      ready = 1'b0;
      auto_clear = 1'b1;
      for (int i = 0; i < N; i++) begin
         enc_data[i] = '0;
         enc_valid[i] = 1'b0;
      end
      repeat (3) cyc();
      check_all_zero("reset_held");
      #3 reset = 1'b0;
      cyc();
      check_all_zero("reset_released");

      // Test 1: single packet from enc0 with ready high.
      $display("test1: enc0 0xDEADBEEF");
      ready = 1'b1;
      push_pkt(0, 32'hDEADBEEF);
      enc_data[0] = 32'hDEADBEEF;
      enc_valid[0] = 1'b1;
      wait_ptr(1, n);
      check("t1_packet_cycles", 32'(n), 9);
      check("t1_ptr", 32'(bus.enc_index_out), 1);

      // Test 2: enc2 raised first, enc0 three cycles later; order must be 0,1,2.
      $display("test2: round-robin ordering");
      do_prog();
      check("t2_ptr_after_prog", 32'(bus.enc_index_out), 0);
      push_pkt(0, 32'hB0B1B2B3);
      push_pkt(1, 32'hC4C5C6C7);
      push_pkt(2, 32'hA8A9AAAB);
      enc_data[2] = 32'hA8A9AAAB;
      enc_valid[2] = 1'b1;
      repeat (3) cyc();
      check("t2_still_wait", 32'(bus.state_out), 0);
      enc_data[0] = 32'hB0B1B2B3;
      enc_valid[0] = 1'b1;
      wait_ptr(1, n);
      repeat (4) cyc();
      check("t2_enc2_ignored_state", 32'(bus.state_out), 0);
      check("t2_enc2_ignored_ptr", 32'(bus.enc_index_out), 1);
      check("t2_enc2_held", 32'(bus.enc_result_valid), 32'h4);
      enc_data[1] = 32'hC4C5C6C7;
      enc_valid[1] = 1'b1;
      wait_ptr(2, n);
      wait_ptr(3, n);
      check("t2_ack_queue_empty", 32'(exp_ack.size()), 0);

      // Test 3: backpressure pattern 1,0,0,1,0,1 repeating.
      $display("test3: backpressure 0x12345678");
      do_prog();
      push_pkt(0, 32'h12345678);
      enc_data[0] = 32'h12345678;
      enc_valid[0] = 1'b1;
      n = 0;
      do begin
         ready = pat[n % 6];
         cyc();
         n++;
      end while (!(bus.state_out == 2'd0 && bus.enc_index_out == 2'd1) && n < 300);
      check("t3_done_in_budget", 32'(n < 300), 1);
      check("t3_nibs_drained", 32'(exp_nib.size()), 0);
      ready = 1'b1;

      // Test 4: five packets wrap the pointer 0,1,2,3,0.
      $display("test4: wrap-around");
      do_prog();
      for (int k = 0; k < 5; k++) begin
         check("t4_ptr_before", 32'(bus.enc_index_out), 32'(k % 4));
         push_pkt(k % 4, t4_data[k]);
         enc_data[k % 4] = t4_data[k];
         enc_valid[k % 4] = 1'b1;
         wait_ptr((k + 1) % 4, n);
      end
      check("t4_ptr_after", 32'(bus.enc_index_out), 1);

      // Test 5: prog while nibble 3 of an enc1 packet is being offered.
      $display("test5: prog mid-packet");
      exp_ack.push_back(4'b0010);
      push_nibs(32'hCAFEF00D, 3);
      enc_data[1] = 32'hCAFEF00D;
      enc_valid[1] = 1'b1;
      repeat (4) cyc();
      check("t5_nib_index", 32'(bus.nibble_index_out), 3);
      check("t5_nib3_data", 32'(bus.qspi_out_data), 32'hE);
      ready = 1'b0;
      do_prog();
      check("t5_valid_dropped", 32'(bus.qspi_out_valid), 0);
      check("t5_ptr", 32'(bus.enc_index_out), 0);
      check("t5_state", 32'(bus.state_out), 0);
      ready = 1'b1;
      repeat (4) cyc();
      check("t5_no_more_nibbles", 32'(bus.qspi_out_valid), 0);
      push_pkt(0, 32'h0F1E2D3C);
      enc_data[0] = 32'h0F1E2D3C;
      enc_valid[0] = 1'b1;
      wait_ptr(1, n);
      check("t5_followup_cycles", 32'(n), 9);

      // Test 6: asynchronous reset between edges while in SHIFT.
      $display("test6: async reset mid-SHIFT");
      do_prog();
      auto_clear = 1'b0;
      ready = 1'b0;
      exp_ack.push_back(4'b0001);
      enc_data[0] = 32'h89ABCDEF;
      enc_valid[0] = 1'b1;
      repeat (2) cyc();
      check("t6_in_shift", 32'(bus.qspi_out_valid), 1);
      #2 reset = 1'b1;
      #1 check_all_zero("t6_async");
      push_pkt(0, 32'h89ABCDEF);
      auto_clear = 1'b1;
      ready = 1'b1;
      #2 reset = 1'b0;
      wait_ptr(1, n);
      check("t6_recollect_cycles", 32'(n), 9);

      cyc();
      check("end_nib_queue_empty", 32'(exp_nib.size()), 0);
      check("end_ack_queue_empty", 32'(exp_ack.size()), 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
